// File: rtl/ei_axi4_pkg.sv
// rtl/ei_axi4_pkg.sv - shared AXI4 burst, response and write-FSM types
package ei_axi4_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2,
    RSVD  = 2'd3
  } burst_t;

  typedef logic [1:0] resp_t;
  localparam resp_t OKAY   = 2'b00;
  localparam resp_t SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } wr_state_t;

  // Bursts of type INCR must stay inside one 4KB page
  localparam int BOUNDARY_4K = 4096;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/ei_axi4_burst_addr_gen.sv
// rtl/ei_axi4_burst_addr_gen.sv - combinational next-beat address for AXI4 bursts
module ei_axi4_burst_addr_gen
  import ei_axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_len,
  input  logic [2:0]            i_size,
  input  burst_t                i_burst,
  output logic [ADDR_WIDTH-1:0] o_next_addr
);

  logic [ADDR_WIDTH-1:0] w_beat_bytes;
  logic [ADDR_WIDTH-1:0] w_aligned;
  logic [ADDR_WIDTH-1:0] w_incr;
  logic [ADDR_WIDTH-1:0] w_wrap_bytes;
  logic [ADDR_WIDTH-1:0] w_wrap_base;

  // Next address: FIXED holds, INCR steps one beat, WRAP steps and folds back to the wrap base
  always_comb begin
    w_beat_bytes = ADDR_WIDTH'(1) << i_size;
    w_aligned    = i_addr & ~(w_beat_bytes - ADDR_WIDTH'(1));
    w_incr       = w_aligned + w_beat_bytes;
    w_wrap_bytes = ADDR_WIDTH'({1'b0, i_len} + 9'd1) << i_size;
    w_wrap_base  = i_addr & ~(w_wrap_bytes - ADDR_WIDTH'(1));
    o_next_addr  = i_addr;
    case (i_burst)
      FIXED:   o_next_addr = i_addr;
      INCR:    o_next_addr = w_incr;
      WRAP:    o_next_addr = (w_incr == (w_wrap_base + w_wrap_bytes)) ? w_wrap_base : w_incr;
      default: o_next_addr = i_addr;
    endcase
  end

endmodule

// File: rtl/ei_axi4_slave_wr_ctrl.sv
// rtl/ei_axi4_slave_wr_ctrl.sv - AXI4 write-path slave turning bursts into registered memory writes
module ei_axi4_slave_wr_ctrl
  import ei_axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_BYTES  = 4096
) (
  input  logic                    i_aclk,
  input  logic                    i_aresetn,
  input  logic [ADDR_WIDTH-1:0]   i_awaddr,
  input  logic [1:0]              i_awburst,
  input  logic [7:0]              i_awlen,
  input  logic [2:0]              i_awsize,
  input  logic                    i_awvalid,
  output logic                    o_awready,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_wlast,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  output logic [1:0]              o_bresp,
  output logic                    o_bvalid,
  input  logic                    i_bready,
  output logic                    o_mem_we,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_wstrb
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int MAX_SIZE   = $clog2(STRB_WIDTH);
  // Extra headroom so burst-span arithmetic near the top of the address space cannot overflow
  localparam int EW         = ADDR_WIDTH + 16;

  wr_state_t              r_state;
  wr_state_t              w_next_state;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [7:0]             r_len;
  logic [2:0]             r_size;
  burst_t                 r_burst;
  logic [7:0]             r_beat_cnt;
  logic                   r_err;
  logic                   w_err_next;

  logic                   r_awready;
  logic                   r_wready;
  logic                   r_bvalid;
  resp_t                  r_bresp;

  logic                   r_mem_we;
  logic [ADDR_WIDTH-1:0]  r_mem_addr;
  logic [DATA_WIDTH-1:0]  r_mem_wdata;
  logic [STRB_WIDTH-1:0]  r_mem_wstrb;

  logic                   w_aw_hs;
  logic                   w_w_hs;
  logic                   w_b_hs;
  logic                   w_last_beat;
  logic                   w_wlast_bad;
  logic [ADDR_WIDTH-1:0]  w_next_addr;
  logic [ADDR_WIDTH-1:0]  w_aw_aligned;

  logic [EW-1:0]          w_aw_beat_bytes;
  logic [EW-1:0]          w_aw_span;
  logic [EW-1:0]          w_aw_start;
  logic [EW-1:0]          w_aw_wrap_base;
  logic [EW-1:0]          w_aw_max_beat;
  logic                   w_aw_err;

  assign w_aw_hs      = i_awvalid && r_awready;
  assign w_w_hs       = i_wvalid && r_wready;
  assign w_b_hs       = r_bvalid && i_bready;
  assign w_last_beat  = (r_beat_cnt == r_len);
  assign w_wlast_bad  = (i_wlast != w_last_beat);
  assign w_aw_aligned = i_awaddr & ~((ADDR_WIDTH'(1) << i_awsize) - ADDR_WIDTH'(1));

  assign o_awready   = r_awready;
  assign o_wready    = r_wready;
  assign o_bvalid    = r_bvalid;
  assign o_bresp     = r_bresp;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_wstrb = r_mem_wstrb;

  ei_axi4_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .i_addr      (r_addr),
    .i_len       (r_len),
    .i_size      (r_size),
    .i_burst     (r_burst),
    .o_next_addr (w_next_addr)
  );

  // Legality of the offered AW request; the result is latched into r_err on acceptance
  always_comb begin
    w_aw_beat_bytes = EW'(1) << i_awsize;
    w_aw_span       = EW'({1'b0, i_awlen} + 9'd1) << i_awsize;
    w_aw_start      = EW'(w_aw_aligned);
    w_aw_wrap_base  = w_aw_start & ~(w_aw_span - EW'(1));
    w_aw_max_beat   = w_aw_start;
    case (burst_t'(i_awburst))
      INCR:    w_aw_max_beat = w_aw_start + w_aw_span - w_aw_beat_bytes;
      WRAP:    w_aw_max_beat = w_aw_wrap_base + w_aw_span - w_aw_beat_bytes;
      default: w_aw_max_beat = w_aw_start;
    endcase
    w_aw_err = 1'b0;
    if (i_awburst == 2'b11) begin
      w_aw_err = 1'b1;
    end
    if (i_awsize > 3'(MAX_SIZE)) begin
      w_aw_err = 1'b1;
    end
    if ((burst_t'(i_awburst) == WRAP) && !wrap_len_ok(i_awlen)) begin
      w_aw_err = 1'b1;
    end
    if ((burst_t'(i_awburst) == INCR) &&
        ((EW'(w_aw_start[11:0]) + w_aw_span) > EW'(BOUNDARY_4K))) begin
      w_aw_err = 1'b1;
    end
    if (w_aw_max_beat >= EW'(MEM_BYTES)) begin
      w_aw_err = 1'b1;
    end
  end

  // Next-state and next error flag; the burst ends on the beat whose count equals len
  always_comb begin
    w_next_state = r_state;
    w_err_next   = r_err;
    case (r_state)
      IDLE: begin
        if (w_aw_hs) begin
          w_next_state = DATA;
          w_err_next   = w_aw_err;
        end
      end
      DATA: begin
        if (w_w_hs) begin
          if (w_wlast_bad) begin
            w_err_next = 1'b1;
          end
          if (w_last_beat) begin
            w_next_state = RESP;
          end
        end
      end
      RESP: begin
        if (w_b_hs) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Handshake outputs follow the next state so they read 0 throughout reset
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
    end else begin
      r_awready <= (w_next_state == IDLE);
      r_wready  <= (w_next_state == DATA);
      r_bvalid  <= (w_next_state == RESP);
      r_bresp   <= ((w_next_state == RESP) && w_err_next) ? SLVERR : OKAY;
    end
  end

  // Burst context captured on AW acceptance, then stepped once per accepted beat
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_burst    <= FIXED;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_err_next;
      if (w_aw_hs) begin
        r_addr     <= w_aw_aligned;
        r_len      <= i_awlen;
        r_size     <= i_awsize;
        r_burst    <= burst_t'(i_awburst);
        r_beat_cnt <= '0;
      end else if (w_w_hs) begin
        r_addr     <= w_next_addr;
        r_beat_cnt <= r_beat_cnt + 8'd1;
      end
    end
  end

  // Memory write port: one registered pulse per accepted beat of an error-free burst
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
    end else begin
      r_mem_we <= w_w_hs && !w_err_next;
      if (w_w_hs) begin
        r_mem_addr  <= r_addr;
        r_mem_wdata <= i_wdata;
        r_mem_wstrb <= i_wstrb;
      end
    end
  end

endmodule
